// File: rtl/fdiv_iter.sv
// -----------------------------------------------------------------------------
// fdiv_iter -- iterative IEEE binary32 divider, d = s / t.
//
// Restoring division producing one quotient bit per clock, followed by a single
// normalise/round cycle. Denormal inputs are treated as zero, rounding is
// round-to-nearest-even, exponent overflow saturates to +/-inf and exponent
// underflow flushes to +/-0. Latency is a fixed 28 edges from the accept edge
// to the first edge showing out_valid, for every operand class.
//
// Ports:
//   clk         in   clock, rising-edge
//   rst         in   asynchronous active-high reset
//   in_valid    in   operands s, t valid
//   in_ready    out  idle, able to accept operands
//   s           in   dividend (binary32)
//   t           in   divisor (binary32)
//   out_valid   out  d and flags valid
//   out_ready   in   consumer takes the result
//   d           out  quotient (binary32)
//   overflow    out  result saturated to +/-inf by exponent overflow
//   underflow   out  result flushed to +/-0 by exponent underflow
//   div_by_zero out  finite nonzero dividend divided by zero
// -----------------------------------------------------------------------------
module fdiv_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] s,
    input  logic [31:0] t,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] d,
    output logic        overflow,
    output logic        underflow,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_NORM = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Operand classification helpers (exponent 0 counts as zero, so denormals flush).
    function automatic logic f_is_nan(input logic [31:0] x);
        f_is_nan = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    function automatic logic f_is_inf(input logic [31:0] x);
        f_is_inf = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    endfunction

    function automatic logic f_is_zero(input logic [31:0] x);
        f_is_zero = (x[30:23] == 8'h00);
    endfunction

    state_t       r_state;
    state_t       w_next_state;

    logic [31:0]  r_s;
    logic [31:0]  r_t;
    logic [25:0]  r_rem;
    logic [25:0]  r_q;
    logic [4:0]   r_cnt;
    logic         r_in_ready;
    logic         r_out_valid;
    logic [31:0]  r_d;
    logic         r_ovf;
    logic         r_unf;
    logic         r_dbz;

    // Division step
    logic [25:0]  w_mt;
    logic         w_ge;
    logic [25:0]  w_diff;
    logic [25:0]  w_rem_next;
    logic [25:0]  w_q_next;

    // Normalise / round
    logic         w_sign;
    logic [23:0]  w_mant;
    logic         w_guard;
    logic         w_sticky;
    logic         w_round_up;
    logic [24:0]  w_mant_sum;
    logic [23:0]  w_mant_rnd;
    logic signed [9:0] w_exp_base;
    logic signed [9:0] w_exp_rnd;
    logic [31:0]  w_res_d;
    logic         w_res_ovf;
    logic         w_res_unf;
    logic         w_res_dbz;

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign d           = r_d;
    assign overflow    = r_ovf;
    assign underflow   = r_unf;
    assign div_by_zero = r_dbz;

    // One restoring step: subtract the divisor when it fits, then shift left.
    always_comb begin
        w_mt = {3'b001, r_t[22:0]};
        w_ge = (r_rem >= w_mt);
        if (w_ge) begin
            w_diff = r_rem - w_mt;
        end else begin
            w_diff = r_rem;
        end
        w_rem_next = w_diff << 1;
        w_q_next   = {r_q[24:0], w_ge};
    end

    // Normalise the 26-bit quotient, round to nearest even, and pick special results.
    always_comb begin
        w_sign = r_s[31] ^ r_t[31];
        if (r_q[25]) begin
            w_mant     = r_q[25:2];
            w_guard    = r_q[1];
            w_sticky   = (r_rem != 26'd0) | r_q[0];
            w_exp_base = $signed({2'b00, r_s[30:23]}) - $signed({2'b00, r_t[30:23]}) + 10'sd127;
        end else begin
            w_mant     = r_q[24:1];
            w_guard    = r_q[0];
            w_sticky   = (r_rem != 26'd0);
            w_exp_base = $signed({2'b00, r_s[30:23]}) - $signed({2'b00, r_t[30:23]}) + 10'sd126;
        end

        w_round_up = w_guard & (w_sticky | w_mant[0]);
        w_mant_sum = {1'b0, w_mant} + {24'd0, w_round_up};
        // A carry out of 24 bits leaves 1.000... and bumps the exponent.
        if (w_mant_sum[24]) begin
            w_mant_rnd = 24'h800000;
            w_exp_rnd  = w_exp_base + 10'sd1;
        end else begin
            w_mant_rnd = w_mant_sum[23:0];
            w_exp_rnd  = w_exp_base;
        end

        w_res_d   = {w_sign, w_exp_rnd[7:0], w_mant_rnd[22:0]};
        w_res_ovf = 1'b0;
        w_res_unf = 1'b0;
        w_res_dbz = 1'b0;

        if (f_is_nan(r_s)) begin
            w_res_d = r_s | 32'h0040_0000;
        end else if (f_is_nan(r_t)) begin
            w_res_d = r_t | 32'h0040_0000;
        end else if ((f_is_inf(r_s) && f_is_inf(r_t)) || (f_is_zero(r_s) && f_is_zero(r_t))) begin
            w_res_d = 32'h7FC0_0000;
        end else if (f_is_inf(r_s)) begin
            w_res_d = {w_sign, 8'hFF, 23'd0};
        end else if (f_is_inf(r_t)) begin
            w_res_d = {w_sign, 31'd0};
        end else if (f_is_zero(r_t)) begin
            w_res_d   = {w_sign, 8'hFF, 23'd0};
            w_res_dbz = 1'b1;
        end else if (f_is_zero(r_s)) begin
            w_res_d = {w_sign, 31'd0};
        end else if (w_exp_rnd >= 10'sd255) begin
            w_res_d   = {w_sign, 8'hFF, 23'd0};
            w_res_ovf = 1'b1;
        end else if (w_exp_rnd <= 10'sd0) begin
            w_res_d   = {w_sign, 31'd0};
            w_res_unf = 1'b1;
        end else begin
            w_res_d = {w_sign, w_exp_rnd[7:0], w_mant_rnd[22:0]};
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_next_state = ST_DIV;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_DIV: begin
                if (r_cnt == 5'd0) begin
                    w_next_state = ST_NORM;
                end else begin
                    w_next_state = ST_DIV;
                end
            end
            ST_NORM: begin
                w_next_state = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_DONE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s         <= 32'd0;
            r_t         <= 32'd0;
            r_rem       <= 26'd0;
            r_q         <= 26'd0;
            r_cnt       <= 5'd0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_d         <= 32'd0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
            r_dbz       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_s        <= s;
                        r_t        <= t;
                        r_rem      <= {3'b001, s[22:0]};
                        r_q        <= 26'd0;
                        r_cnt      <= 5'd25;
                        r_in_ready <= 1'b0;
                        r_ovf      <= 1'b0;
                        r_unf      <= 1'b0;
                        r_dbz      <= 1'b0;
                    end
                end
                ST_DIV: begin
                    r_rem <= w_rem_next;
                    r_q   <= w_q_next;
                    if (r_cnt != 5'd0) begin
                        r_cnt <= r_cnt - 5'd1;
                    end
                end
                ST_NORM: begin
                    r_d         <= w_res_d;
                    r_ovf       <= w_res_ovf;
                    r_unf       <= w_res_unf;
                    r_dbz       <= w_res_dbz;
                    r_out_valid <= 1'b1;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fdiv_iter.sv
// -----------------------------------------------------------------------------
// tb_fdiv_iter -- directed, table-driven bench for fdiv_iter, plus hand-written
// backpressure and mid-operation reset sequences.
// -----------------------------------------------------------------------------
module tb_fdiv_iter;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] s;
    logic [31:0] t;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] d;
    logic        overflow;
    logic        underflow;
    logic        div_by_zero;

    int n_pass;
    int n_total;

    fdiv_iter dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .s           (s),
        .t           (t),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .d           (d),
        .overflow    (overflow),
        .underflow   (underflow),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] s;
        logic [31:0] t;
        logic [31:0] d;
        logic [2:0]  flags;   // {overflow, underflow, div_by_zero}
    } vec_t;

    vec_t vecs [18];

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    // Accept one operation, then wait (bounded) for out_valid; edges counts the accept edge.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, output int edges);
        @(negedge clk);
        s        = a;
        t        = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        s        = 32'hDEAD_BEEF;
        t        = 32'h1234_5678;
        edges    = 1;
        while (!out_valid && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    initial begin
        int edges;
        n_pass    = 0;
        n_total   = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        s         = 32'd0;
        t         = 32'd0;

        vecs[0]  = '{"6div2",       32'h40C00000, 32'h40000000, 32'h40400000, 3'b000};
        vecs[1]  = '{"1div3",       32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 3'b000};
        vecs[2]  = '{"m1div3",      32'hBF800000, 32'h40400000, 32'hBEAAAAAB, 3'b000};
        vecs[3]  = '{"1div2",       32'h3F800000, 32'h40000000, 32'h3F000000, 3'b000};
        vecs[4]  = '{"1div0",       32'h3F800000, 32'h00000000, 32'h7F800000, 3'b001};
        vecs[5]  = '{"0div0",       32'h00000000, 32'h00000000, 32'h7FC00000, 3'b000};
        vecs[6]  = '{"snan_s",      32'h7FA00000, 32'h3F800000, 32'h7FE00000, 3'b000};
        vecs[7]  = '{"1divninf",    32'h3F800000, 32'hFF800000, 32'h80000000, 3'b000};
        vecs[8]  = '{"overflow",    32'h7F000000, 32'h3E800000, 32'h7F800000, 3'b100};
        vecs[9]  = '{"underflow",   32'h00800000, 32'h40800000, 32'h00000000, 3'b010};
        vecs[10] = '{"nan_t",       32'h3F800000, 32'hFF800001, 32'hFFC00001, 3'b000};
        vecs[11] = '{"infdivinf",   32'h7F800000, 32'hFF800000, 32'h7FC00000, 3'b000};
        vecs[12] = '{"ninfdiv2",    32'hFF800000, 32'h40000000, 32'hFF800000, 3'b000};
        vecs[13] = '{"0div5",       32'h00000000, 32'h40A00000, 32'h00000000, 3'b000};
        vecs[14] = '{"m1divdenorm", 32'hBF800000, 32'h00400000, 32'hFF800000, 3'b001};
        vecs[15] = '{"m0div3",      32'h80000000, 32'h40400000, 32'h80000000, 3'b000};
        vecs[16] = '{"2div3",       32'h40000000, 32'h40400000, 32'h3F2AAAAB, 3'b000};
        vecs[17] = '{"1p5div1p5",   32'h3FC00000, 32'h3FC00000, 32'h3F800000, 3'b000};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_d",         d,                  32'd0);
        check("rst_flags",     {29'd0, overflow, underflow, div_by_zero}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven vectors with out_ready held high
        for (int i = 0; i < 18; i++) begin
            run_op(vecs[i].s, vecs[i].t, edges);
            check({vecs[i].name, "_latency"}, edges, 32'd28);
            check({vecs[i].name, "_d"}, d, vecs[i].d);
            check({vecs[i].name, "_flags"}, {29'd0, overflow, underflow, div_by_zero},
                  {29'd0, vecs[i].flags});
            @(posedge clk);
            #1;
            check({vecs[i].name, "_release"}, {30'd0, out_valid, in_ready}, 32'd1);
        end

        // Backpressure: result held for 10 cycles, new operands ignored
        out_ready = 1'b0;
        run_op(32'h3F800000, 32'h40400000, edges);
        check("bp_latency", edges, 32'd28);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            s        = 32'h40C00000;
            t        = 32'h40000000;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            check("bp_d_hold", d, 32'h3EAAAAAB);
            check("bp_flags_hold", {29'd0, overflow, underflow, div_by_zero}, 32'd0);
            check("bp_handshake", {30'd0, out_valid, in_ready}, 32'd2);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release", {30'd0, out_valid, in_ready}, 32'd1);
        run_op(32'h40C00000, 32'h40000000, edges);
        check("bp_next_latency", edges, 32'd28);
        check("bp_next_d", d, 32'h40400000);

        // Reset during DIV aborts the operation immediately
        @(posedge clk);
        @(negedge clk);
        s        = 32'h3F800000;
        t        = 32'h40400000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("mid_rst_d", d, 32'd0);
        check("mid_rst_handshake", {30'd0, out_valid, in_ready}, 32'd1);
        check("mid_rst_flags", {29'd0, overflow, underflow, div_by_zero}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(32'h40C00000, 32'h40000000, edges);
        check("post_rst_latency", edges, 32'd28);
        check("post_rst_d", d, 32'h40400000);
        check("post_rst_flags", {29'd0, overflow, underflow, div_by_zero}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
